alu_arbiter: RTL

// Shares one alu instance between NUM_REQ requesters, e.g. the execute stage
// and the branch/address unit. Each request is op + two operands over a

---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between NUM_REQ requesters.
//
// riscv_pkg supplies the ALU operation type shared with the external alu.
//
// Ports (alu_arbiter):
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o  per-requester request handshake (ready one-hot or zero)
//   req_op_i, req_a_i, req_b_i per-requester op and packed operands (req0 in LSBs)
//   rsp_valid_o / rsp_ready_i  per-requester response handshake (valid one-hot or zero)
//   rsp_result_o, rsp_zero_o   registered ALU result and zero flag, shared by all
//   alu_op_o, alu_a_o, alu_b_o operands driven to the shared alu
//   alu_result_i, alu_zero_i   result returned by the shared alu
//
// One transaction is in flight at a time: IDLE (arbitrate) -> EXEC (alu
// evaluates latched operands) -> RESP (hold result until accepted) -> IDLE.

package riscv_pkg;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } alu_op_t;
endpackage

module alu_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REQ   = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  riscv_pkg::alu_op_t [NUM_REQ-1:0]   req_op_i,
  input  logic [NUM_REQ*WORD_SIZE-1:0]       req_a_i,
  input  logic [NUM_REQ*WORD_SIZE-1:0]       req_b_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  input  logic [NUM_REQ-1:0]                 rsp_ready_i,
  output logic [WORD_SIZE-1:0]               rsp_result_o,
  output logic                               rsp_zero_o,
  output riscv_pkg::alu_op_t                 alu_op_o,
  output logic [WORD_SIZE-1:0]               alu_a_o,
  output logic [WORD_SIZE-1:0]               alu_b_o,
  input  logic [WORD_SIZE-1:0]               alu_result_i,
  input  logic                               alu_zero_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // One extra bit so ptr + offset can exceed NUM_REQ before wrapping.
  localparam int CW    = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic [CW-1:0]    cand_raw;
  logic [CW-1:0]    cand;
  logic             hit;
  logic             req_fire;
  logic             rsp_fire;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first valid requester starting at ptr, wrapping mod NUM_REQ
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    cand_raw = '0;
    cand     = '0;
    hit      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_raw = {1'b0, ptr} + CW'(k);
      cand     = (cand_raw >= CW'(NUM_REQ)) ? (cand_raw - CW'(NUM_REQ)) : cand_raw;
      hit      = !found && req_valid_i[cand[IDX_W-1:0]];
      sel      = hit ? cand[IDX_W-1:0] : sel;
      found    = found | hit;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_next  = state;
    req_ready_o = '0;
    req_fire    = 1'b0;
    rsp_fire    = 1'b0;
    case (state)
      IDLE: begin
        // Ready is gated by rst_ni so it reads zero while reset is asserted.
        if (found && rst_ni) begin
          req_ready_o = onehot(sel);
          req_fire    = 1'b1;
          state_next  = EXEC;
        end else begin
          state_next  = IDLE;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready_i[grant]) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch, result capture, response valid and priority pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr          <= '0;
      grant        <= '0;
      alu_op_o     <= riscv_pkg::ADD;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      rsp_valid_o  <= '0;
    end else begin
      if (req_fire) begin
        grant    <= sel;
        alu_op_o <= req_op_i[sel];
        alu_a_o  <= req_a_i[sel*WORD_SIZE +: WORD_SIZE];
        alu_b_o  <= req_b_i[sel*WORD_SIZE +: WORD_SIZE];
      end
      if (state == EXEC) begin
        rsp_result_o <= alu_result_i;
        rsp_zero_o   <= alu_zero_i;
        rsp_valid_o  <= onehot(grant);
      end
      if (rsp_fire) begin
        // Lowest priority goes to the requester just served.
        ptr         <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : (grant + IDX_W'(1));
        rsp_valid_o <= '0;
      end
    end
  end

endmodule
